grf_wr_arbiter: RTL and testbench
=================================

Name: grf_wr_arbiter

Overview:
- Shares the single GRF write port (WE3/A3/WD/PC) between two writeback requesters.
- Requester 0 is the main pipeline W stage. Requester 1 is a secondary writer, such as the multi-cycle mult/div or a late load unit.
- Fixed priority to requester 0, with a starvation override for requester 1.
- The granted write is registered and driven to the GRF for exactly one cycle. PC is forwarded so the GRF write log stays correct.

Parameters:
- STARVE_LIMIT, 3: consecutive cycles requester 1 may be refused before it is forced through. Legal range is 1..(2^CNT_W - 1).
- CNT_W, 2: width of the starvation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a write pending
- req0_ready  output  1  requester 0 write accepted this cycle (combinational)
- req0_addr  input  5  destination register, requester 0
- req0_data  input  32  write data, requester 0
- req0_pc  input  32  PC of the instruction producing the write, requester 0
- req1_valid  input  1  requester 1 has a write pending
- req1_ready  output  1  requester 1 write accepted this cycle (combinational)
- req1_addr  input  5  destination register, requester 1
- req1_data  input  32  write data, requester 1
- req1_pc  input  32  PC of the instruction producing the write, requester 1
- grf_we  output  1  to GRF WE3 (registered)
- grf_a3  output  5  to GRF A3 (registered)
- grf_wd  output  32  to GRF WD (registered)
- grf_pc  output  32  to GRF PC (registered)
- grf_src  output  1  source of the current grf_* write, 0 or 1 (registered; debug)
- starve_cnt  output  CNT_W  current starvation count (debug)

Behaviour:
- Handshake:
  - A transfer occurs on a rising edge where reqX_valid && reqX_ready.
  - A requester holds valid/addr/data/pc stable until accepted.
  - valid is never withdrawn before acceptance.
- Override: override = (starve_cnt == STARVE_LIMIT).
- Grant (combinational, at most one ready per cycle):
  - req0_ready = !reset && req0_valid && !(override && req1_valid).
  - req1_ready = !reset && req1_valid && (!req0_valid || override).
- Starvation counter:
  - Cleared on a req1 transfer, or when req1_valid == 0.
  - Incremented when req1_valid && !req1_ready.
  - Saturates at STARVE_LIMIT.
- Output register, on each edge:
  - If a transfer occurs: grf_a3/grf_wd/grf_pc/grf_src load the winner's fields, and grf_we <= (winner addr != 0).
  - Otherwise grf_we <= 0. grf_a3, grf_wd and grf_pc hold their previous values.
- Latency:
  - A request accepted at edge N appears on grf_* during cycle N..N+1.
  - The GRF commits it at edge N+1.
  - One write per cycle; sustained throughput is 1 write/cycle.
- Address 0: the handshake completes normally and grf_we stays 0. The request is consumed and dropped, and does not count toward starvation.
- Same address from both requesters in one cycle: only the winner is accepted. The loser is written on a later cycle, so the last GRF value is the later-accepted one.
- Reset, synchronous:
  - grf_we, grf_a3, grf_wd, grf_pc, grf_src and starve_cnt are all 0.
  - Both readies are 0 while reset is high.
  - A write registered in the cycle before reset asserts is still presented for its one cycle. Asserting reset on that edge clears it (grf_we = 0).
  - Pending requests are not remembered across reset.
- No internal queue. Backpressure is carried solely by ready.

Test Plan:
- Reset: assert reset 2 cycles with both valid=1 -> req0_ready=req1_ready=0, grf_we=0, grf_pc=0, starve_cnt=0.
- Single writer:
  - Stimulus: req0 {addr=1, data=99, pc=0x3004}, valid for 1 cycle.
  - Required: req0_ready=1; next cycle grf_we=1, grf_a3=1, grf_wd=99, grf_pc=0x3004, grf_src=0; the following cycle grf_we=0.
- Back-to-back and read-back:
  - Stimulus: req0 writes addr 2=2 then addr 3=3 on consecutive cycles.
  - Required: grf_we high 2 consecutive cycles with a3=2 then 3.
  - With the GRF attached: A1=2, A2=3 read RD1=2, RD2=3.
- Priority and starvation (STARVE_LIMIT=3):
  - Stimulus: req0_valid held 1 continuously; req1 {addr=5, data=0x55} valid.
  - Required: req1 refused 3 cycles (starve_cnt 1,2,3); on the 4th cycle req1_ready=1, req0_ready=0; next cycle grf_a3=5, grf_src=1; starve_cnt returns to 0 and req0 resumes.
- Address 0: req1 {addr=0, data=10} alone -> req1_ready=1, grf_we stays 0, starve_cnt=0.
- Conflict and reset mid-stream:
  - Conflict: both requesters target addr 4 with data 0xA then 0xB. Required: req0 wins first, req1 next cycle; final GRF $4=0xB.
  - Reset mid-stream: assert reset while req1 is waiting with starve_cnt=2. Required: counter 0, no write emitted.

Source files
------------

// File: rtl/grf_wr_if.sv
// ---------------------------------------------------------------------------
// grf_wr_if
//
// Purpose:
//   Bundles the two writeback request channels and the registered GRF write
//   port driven by grf_wr_arbiter.
//
// Signal summary:
//   req0_valid/ready, req0_addr[4:0], req0_data[31:0], req0_pc[31:0]
//       requester 0 (main pipeline W stage)
//   req1_valid/ready, req1_addr[4:0], req1_data[31:0], req1_pc[31:0]
//       requester 1 (secondary writer, e.g. mult/div or late load)
//   grf_we, grf_a3[4:0], grf_wd[31:0], grf_pc[31:0]
//       registered write toward the GRF (WE3/A3/WD/PC)
//   grf_src     which requester produced the current grf_* write (debug)
//   starve_cnt  requester 1 starvation count (debug)
//
// Modports:
//   master : the requester / GRF side (drives requests, observes the rest)
//   slave  : the arbiter side
// ---------------------------------------------------------------------------
interface grf_wr_if #(
  parameter int CNT_W = 2
);
  // Requester 0
  logic             req0_valid;
  logic             req0_ready;
  logic [4:0]       req0_addr;
  logic [31:0]      req0_data;
  logic [31:0]      req0_pc;

  // Requester 1
  logic             req1_valid;
  logic             req1_ready;
  logic [4:0]       req1_addr;
  logic [31:0]      req1_data;
  logic [31:0]      req1_pc;

  // GRF write port
  logic             grf_we;
  logic [4:0]       grf_a3;
  logic [31:0]      grf_wd;
  logic [31:0]      grf_pc;

  // Debug
  logic             grf_src;
  logic [CNT_W-1:0] starve_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data, req0_pc,
    output req1_valid, req1_addr, req1_data, req1_pc,
    input  req0_ready, req1_ready,
    input  grf_we, grf_a3, grf_wd, grf_pc, grf_src, starve_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req0_pc,
    input  req1_valid, req1_addr, req1_data, req1_pc,
    output req0_ready, req1_ready,
    output grf_we, grf_a3, grf_wd, grf_pc, grf_src, starve_cnt
  );
endinterface

// File: rtl/grf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// grf_wr_arbiter
//
// Purpose:
//   Shares the single GRF write port between two writeback requesters.
//   Requester 0 has fixed priority; requester 1 is forced through once it
//   has been refused STARVE_LIMIT consecutive cycles. The granted write is
//   registered and presented to the GRF for exactly one cycle, together with
//   its PC so the GRF write log stays correct. There is no internal queue:
//   backpressure is carried solely by the ready signals.
//
// Parameters:
//   STARVE_LIMIT  refusals of requester 1 before it is forced through
//                 (1 .. 2**CNT_W-1)
//   CNT_W         width of the starvation counter
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    grf_wr_if slave modport: both request channels (valid/ready,
//          addr, data, pc), the registered GRF write (we/a3/wd/pc) and the
//          debug outputs grf_src / starve_cnt
// ---------------------------------------------------------------------------
module grf_wr_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic     clk,
  input  logic     reset,
  grf_wr_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic             grf_we_q,  grf_we_d;
  logic [4:0]       grf_a3_q,  grf_a3_d;
  logic [31:0]      grf_wd_q,  grf_wd_d;
  logic [31:0]      grf_pc_q,  grf_pc_d;
  logic             grf_src_q, grf_src_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // -------------------------------------------------------------------------
  // Grant
  // -------------------------------------------------------------------------
  logic override;
  logic grant0;
  logic grant1;

  always_comb begin
    // Requester 1 has waited long enough: it beats requester 0 this cycle.
    override = (cnt_q == LIMIT);
    // The two grants are mutually exclusive by construction; both are held
    // low during reset so nothing is consumed that would then be lost.
    grant0   = !reset && bus.req0_valid && !(override && bus.req1_valid);
    grant1   = !reset && bus.req1_valid && (!bus.req0_valid || override);
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // -------------------------------------------------------------------------
  // Next-state: output register
  // -------------------------------------------------------------------------
  always_comb begin
    // Without a transfer the write strobe drops, the payload holds.
    grf_we_d  = 1'b0;
    grf_a3_d  = grf_a3_q;
    grf_wd_d  = grf_wd_q;
    grf_pc_d  = grf_pc_q;
    grf_src_d = grf_src_q;

    if (grant0) begin
      grf_a3_d  = bus.req0_addr;
      grf_wd_d  = bus.req0_data;
      grf_pc_d  = bus.req0_pc;
      grf_src_d = 1'b0;
      // A write to $0 is accepted and dropped: no strobe toward the GRF.
      grf_we_d  = (bus.req0_addr != 5'd0);
    end else if (grant1) begin
      grf_a3_d  = bus.req1_addr;
      grf_wd_d  = bus.req1_data;
      grf_pc_d  = bus.req1_pc;
      grf_src_d = 1'b1;
      grf_we_d  = (bus.req1_addr != 5'd0);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state: starvation counter
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (!bus.req1_valid || grant1) begin
      // Nothing waiting, or the waiter just got through (including a
      // consumed $0 write): the refusal streak is over.
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      // Refused this cycle; saturate so the override stays asserted until
      // requester 1 is actually accepted.
      cnt_d = cnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we_q  <= 1'b0;
      grf_a3_q  <= 5'd0;
      grf_wd_q  <= 32'd0;
      grf_pc_q  <= 32'd0;
      grf_src_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      grf_we_q  <= grf_we_d;
      grf_a3_q  <= grf_a3_d;
      grf_wd_q  <= grf_wd_d;
      grf_pc_q  <= grf_pc_d;
      grf_src_q <= grf_src_d;
      cnt_q     <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.grf_we     = grf_we_q;
  assign bus.grf_a3     = grf_a3_q;
  assign bus.grf_wd     = grf_wd_q;
  assign bus.grf_pc     = grf_pc_q;
  assign bus.grf_src    = grf_src_q;
  assign bus.starve_cnt = cnt_q;

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_grf_wr_arbiter
//
// Self-checking bench for grf_wr_arbiter. Each test task drives one scenario
// and compares the combinational readies and registered outputs inline.
// Every write the bench expects the DUT to accept is pushed to a scoreboard
// queue tagged with the cycle it must appear on grf_*; the scoreboard is
// checked after every clock edge. A small GRF model records committed writes
// for read-back checks.
// ---------------------------------------------------------------------------
module tb_grf_wr_arbiter;

  localparam int CNT_W = 2;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  grf_wr_if #(.CNT_W(CNT_W)) bus ();

  grf_wr_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        src;
    int          due;
  } exp_t;

  exp_t sb[$];

  // GRF model: commits a write on the edge after it is presented.
  logic [31:0] regs [0:31];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (bus.grf_we === 1'b1 && bus.grf_a3 != 5'd0) begin
      regs[bus.grf_a3] <= bus.grf_wd;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic set0(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_data = d; bus.req0_pc = pc;
  endtask

  task automatic set1(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_data = d; bus.req1_pc = pc;
  endtask

  task automatic clr0();
    bus.req0_valid = 1'b0; bus.req0_addr = 5'd0; bus.req0_data = 32'd0; bus.req0_pc = 32'd0;
  endtask

  task automatic clr1();
    bus.req1_valid = 1'b0; bus.req1_addr = 5'd0; bus.req1_data = 32'd0; bus.req1_pc = 32'd0;
  endtask

  // Expect an accepted write to be presented on grf_* after the next edge.
  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
                      input logic src);
    exp_t e;
    if (a != 5'd0) begin
      e.a3 = a; e.wd = d; e.pc = pc; e.src = src; e.due = cyc + 1;
      sb.push_back(e);
    end
  endtask

  // Scoreboard: compares the registered write presented in this cycle.
  task automatic sb_check();
    exp_t e;
    tests++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (bus.grf_we !== 1'b1 || bus.grf_a3 !== e.a3 || bus.grf_wd !== e.wd ||
          bus.grf_pc !== e.pc || bus.grf_src !== e.src) begin
        fails++;
        $display("FAIL sb_write cyc=%0d got we=%b a3=%0d wd=%h pc=%h src=%b want we=1 a3=%0d wd=%h pc=%h src=%b",
                 cyc, bus.grf_we, bus.grf_a3, bus.grf_wd, bus.grf_pc, bus.grf_src,
                 e.a3, e.wd, e.pc, e.src);
      end else begin
        $display("[TB] cyc=%0d write a3=%0d wd=%h pc=%h src=%b ok",
                 cyc, e.a3, e.wd, e.pc, e.src);
      end
    end else if (bus.grf_we !== 1'b0) begin
      fails++;
      $display("FAIL sb_idle cyc=%0d got we=%b a3=%0d want we=0", cyc, bus.grf_we, bus.grf_a3);
    end
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sb_check();
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    set0(5'd7, 32'h77, 32'h3000);
    set1(5'd8, 32'h88, 32'h3100);
    tick();
    tick();
    #1;
    tests++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got r0=%b r1=%b want 0 0", bus.req0_ready, bus.req1_ready);
    end
    tests++;
    if (bus.grf_we !== 1'b0 || bus.grf_pc !== 32'd0 || bus.starve_cnt !== 2'd0) begin
      fails++;
      $display("FAIL reset_state got we=%b pc=%h cnt=%0d want 0 0 0",
               bus.grf_we, bus.grf_pc, bus.starve_cnt);
    end
    clr0();
    clr1();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_writer();
    set0(5'd1, 32'd99, 32'h3004);
    #1;
    tests++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL single_ready got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
    end
    push(5'd1, 32'd99, 32'h3004, 1'b0);
    tick();
    clr0();
    tests++;
    if (bus.grf_we !== 1'b1 || bus.grf_a3 !== 5'd1 || bus.grf_wd !== 32'd99 ||
        bus.grf_pc !== 32'h3004 || bus.grf_src !== 1'b0) begin
      fails++;
      $display("FAIL single_out got we=%b a3=%0d wd=%0d pc=%h src=%b want 1 1 99 3004 0",
               bus.grf_we, bus.grf_a3, bus.grf_wd, bus.grf_pc, bus.grf_src);
    end
    tick();
    tests++;
    if (bus.grf_we !== 1'b0) begin
      fails++;
      $display("FAIL single_we_drop got we=%b want 0", bus.grf_we);
    end
  endtask

  task automatic test_back_to_back();
    set0(5'd2, 32'd2, 32'h3008);
    #1;
    tests++;
    if (bus.req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready1 got r0=%b want 1", bus.req0_ready);
    end
    push(5'd2, 32'd2, 32'h3008, 1'b0);
    tick();
    set0(5'd3, 32'd3, 32'h300c);
    #1;
    tests++;
    if (bus.req0_ready !== 1'b1 || bus.grf_we !== 1'b1 || bus.grf_a3 !== 5'd2) begin
      fails++;
      $display("FAIL b2b_first got r0=%b we=%b a3=%0d want 1 1 2",
               bus.req0_ready, bus.grf_we, bus.grf_a3);
    end
    push(5'd3, 32'd3, 32'h300c, 1'b0);
    tick();
    clr0();
    tests++;
    if (bus.grf_we !== 1'b1 || bus.grf_a3 !== 5'd3) begin
      fails++;
      $display("FAIL b2b_second got we=%b a3=%0d want 1 3", bus.grf_we, bus.grf_a3);
    end
    tick();
    tests++;
    if (regs[2] !== 32'd2 || regs[3] !== 32'd3) begin
      fails++;
      $display("FAIL b2b_readback got rd1=%0d rd2=%0d want 2 3", regs[2], regs[3]);
    end
  endtask

  task automatic test_starvation();
    int k = 0;
    set1(5'd5, 32'h55, 32'h4000);
    for (int i = 0; i <= LIMIT; i++) begin
      set0(5'(6 + k), 32'h600 + k, 32'h5000 + 4 * k);
      #1;
      tests++;
      if (bus.starve_cnt !== 2'(i)) begin
        fails++;
        $display("FAIL starve_cnt step=%0d got %0d want %0d", i, bus.starve_cnt, i);
      end
      tests++;
      if (i < LIMIT) begin
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
          fails++;
          $display("FAIL starve_refuse step=%0d got r0=%b r1=%b want 1 0",
                   i, bus.req0_ready, bus.req1_ready);
        end
        push(5'(6 + k), 32'h600 + k, 32'h5000 + 4 * k, 1'b0);
        k++;
      end else begin
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
          fails++;
          $display("FAIL starve_force got r0=%b r1=%b want 0 1",
                   bus.req0_ready, bus.req1_ready);
        end
        push(5'd5, 32'h55, 32'h4000, 1'b1);
      end
      tick();
    end
    clr1();
    #1;
    tests++;
    if (bus.grf_a3 !== 5'd5 || bus.grf_src !== 1'b1 || bus.starve_cnt !== 2'd0 ||
        bus.req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL starve_after got a3=%0d src=%b cnt=%0d r0=%b want 5 1 0 1",
               bus.grf_a3, bus.grf_src, bus.starve_cnt, bus.req0_ready);
    end
    push(5'(6 + k), 32'h600 + k, 32'h5000 + 4 * k, 1'b0);
    tick();
    clr0();
    tick();
  endtask

  task automatic test_addr0();
    set1(5'd0, 32'd10, 32'h4100);
    #1;
    tests++;
    if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      fails++;
      $display("FAIL addr0_ready got r0=%b r1=%b want 0 1", bus.req0_ready, bus.req1_ready);
    end
    tick();
    clr1();
    tests++;
    if (bus.grf_we !== 1'b0 || bus.starve_cnt !== 2'd0) begin
      fails++;
      $display("FAIL addr0_out got we=%b cnt=%0d want 0 0", bus.grf_we, bus.starve_cnt);
    end
    tick();
  endtask

  task automatic test_conflict();
    set0(5'd4, 32'hA, 32'h6000);
    set1(5'd4, 32'hB, 32'h6004);
    #1;
    tests++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL conflict_first got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
    end
    push(5'd4, 32'hA, 32'h6000, 1'b0);
    tick();
    clr0();
    #1;
    tests++;
    if (bus.req1_ready !== 1'b1 || bus.starve_cnt !== 2'd1) begin
      fails++;
      $display("FAIL conflict_second got r1=%b cnt=%0d want 1 1", bus.req1_ready, bus.starve_cnt);
    end
    push(5'd4, 32'hB, 32'h6004, 1'b1);
    tick();
    clr1();
    tick();
    tick();
    tests++;
    if (regs[4] !== 32'hB) begin
      fails++;
      $display("FAIL conflict_final got $4=%h want 0000000b", regs[4]);
    end
  endtask

  task automatic test_reset_midstream();
    set1(5'd9, 32'h99, 32'h7000);
    for (int i = 0; i < 2; i++) begin
      set0(5'(10 + i), 32'h1000 + i, 32'h7100 + 4 * i);
      #1;
      tests++;
      if (bus.req0_ready !== 1'b1 || bus.starve_cnt !== 2'(i)) begin
        fails++;
        $display("FAIL mid_pre step=%0d got r0=%b cnt=%0d want 1 %0d",
                 i, bus.req0_ready, bus.starve_cnt, i);
      end
      push(5'(10 + i), 32'h1000 + i, 32'h7100 + 4 * i, 1'b0);
      tick();
    end
    set0(5'd12, 32'h1002, 32'h7108);
    #1;
    tests++;
    if (bus.starve_cnt !== 2'd2) begin
      fails++;
      $display("FAIL mid_cnt2 got cnt=%0d want 2", bus.starve_cnt);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_ready got r0=%b r1=%b want 0 0", bus.req0_ready, bus.req1_ready);
    end
    tick();
    tests++;
    if (bus.starve_cnt !== 2'd0 || bus.grf_we !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got cnt=%0d we=%b want 0 0", bus.starve_cnt, bus.grf_we);
    end
    clr0();
    clr1();
    tick();
    reset = 1'b0;
    tick();
    tests++;
    if (bus.starve_cnt !== 2'd0 || bus.grf_we !== 1'b0) begin
      fails++;
      $display("FAIL mid_after got cnt=%0d we=%b want 0 0", bus.starve_cnt, bus.grf_we);
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence
  // -------------------------------------------------------------------------
  initial begin
    clr0();
    clr1();
    test_reset();
    test_single_writer();
    test_back_to_back();
    test_starvation();
    test_addr0();
    test_conflict();
    test_reset_midstream();
    tick();
    tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain got %0d pending writes want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
